controle_ula_seq: RTL
=====================

# controle_ula_seq

Parametrised successor of the ALU control decoder. It keeps the combinational `ula_control`/`controle_jr` decode for single-cycle R-type and immediate ops. It adds a sequencer that runs iterative multiply/divide (signed and unsigned) into internal HI/LO registers and stalls the core while busy. It sits between the main control unit and the ALU in the MIPS datapath, replacing the purely combinational ALU control.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and HI/LO width, ≥4, even.
- `FUNCT_WIDTH`, 6: width of the `funcao` field, ≥6; only the low 6 bits are decoded.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ula_opcode`  in  2: 00 add (lw/sw), 01 sub (beq), 10 use `funcao`, 11 or (ori).
- `funcao`  in  FUNCT_WIDTH: R-type funct field.
- `valido`  in  1: instruction in decode is real; gates the start of multi-cycle ops only.
- `operando_a`, `operando_b`  in  DATA_WIDTH each: rs and rt values.
- `ula_control`  out  3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `controle_jr`  out  1: jr select.
- `ocupado`  out  1: multiply/divide in progress; core must stall.
- `pronto`  out  1: one-cycle pulse; HI/LO just updated.
- `erro_div0`  out  1: one-cycle pulse with `pronto` when the divisor was 0.
- `resultado_mf`  out  DATA_WIDTH: HI for mfhi, LO for mflo, else 0.
- `hi`, `lo`  out  DATA_WIDTH each: architectural HI/LO.

## Operation
- Combinational decode, independent of state and `valido`:
  - `ula_opcode`=10, funct 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111.
  - Any other funct → 010.
  - `controle_jr`=1 iff `ula_opcode`=10 and funct=001000.
- Multi-cycle start requires `valido`=1, `ula_opcode`=10, funct ∈ {011000 mult, 011001 multu, 011010 div, 011011 divu} and state OCIOSO.
  - On start, operands are captured (magnitudes for signed ops) together with the result signs.
  - The iteration counter is loaded with DATA_WIDTH-1.
- FSM states:
  - OCIOSO → MULT or DIV on start.
  - DIV → AJUSTE directly if the divisor is 0 (no iterations).
  - MULT/DIV → AJUSTE when the counter reaches 0 (DATA_WIDTH iterations, one bit each).
  - AJUSTE → OCIOSO. Signs are applied and HI/LO are written.
- MULT uses shift-add: LO = low half, HI = high half of the 2·DATA_WIDTH product.
  - For mult, the product is negated iff sign(a)≠sign(b).
- DIV uses restoring division: LO = quotient, HI = remainder.
  - Signed: quotient negated iff signs differ; remainder takes the dividend's sign.
  - Most-negative ÷ -1 gives LO=most-negative, HI=0 (wrap, no flag).
- Divide by zero: HI=dividend as given, LO=all ones, `erro_div0` pulses.
- mfhi (010000) / mflo (010010) with `ula_opcode`=10: `resultado_mf` = `hi`/`lo` combinationally.
- While `ocupado`=1:
  - all `valido` starts are ignored;
  - mf reads return the old HI/LO, and the core must not issue them because it is stalled.

## Timing
- Decode outputs have zero latency (combinational).
- Start edge E0. `ocupado`=1 from after E0 until after edge E(DATA_WIDTH+1).
- HI/LO are updated and `pronto`=1 for the single cycle following E(DATA_WIDTH+1).
  - Back-to-back start is possible on that cycle.
- Divide by zero: AJUSTE after E0; HI/LO written, `pronto`=`erro_div0`=1 after E1. `ocupado` is high for 1 cycle.
- Reset (any time, including mid-operation) asynchronously sets:
  - state OCIOSO, counter 0;
  - `hi`=`lo`=0;
  - `ocupado`=`pronto`=`erro_div0`=0.
  - Any in-flight result is discarded.
- `pronto` and `erro_div0` are registered. `ocupado` is derived from the registered state (≠OCIOSO).

## Structure
- Package `ula_pkg`:
  - funct constants;
  - `ula_control` codes;
  - `ula_opcode` codes;
  - state enum {OCIOSO, MULT, DIV, AJUSTE}.
- One sub-module, `unidade_mult_div`: the iterative datapath (accumulator, shift registers, counter, sign fix-up).
  - It is driven by the FSM and decode in `controle_ula_seq`.

## Test plan
- Exhaustive decode: all 4 opcodes × all 64 functs.
  - funct 101010 with op 10 → 111.
  - op 11 → 001 for every funct.
  - `controle_jr`=1 only for 10/001000.
- multu, DATA_WIDTH=32:
  - a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - `pronto` 34th cycle after start; `ocupado` high 33 cycles.
- mult: a=-7, b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div: a=-7, b=2 → LO=-3, HI=-1.
  - divu 0x80000000/0xFFFFFFFF → LO=0, HI=0x80000000.
- div by zero: a=5, b=0 → after 2 edges HI=5, LO=0xFFFFFFFF, `erro_div0`=`pronto`=1 for one cycle.
- Stall and reset:
  - a second mult asserted with `valido` while `ocupado` is ignored (HI/LO reflect only the first).
  - `reset_n` low mid-DIV clears HI/LO/`ocupado` immediately; the next start runs normally.

Source files
------------

// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// ula_pkg : shared opcode/funct/ALU codes and sequencer states for the
//           ALU control decoder with iterative multiply/divide.
// Rev 1.0
// ============================================================================
package ula_pkg;

    localparam logic [1:0] c_op_add   = 2'b00;
    localparam logic [1:0] c_op_sub   = 2'b01;
    localparam logic [1:0] c_op_funct = 2'b10;
    localparam logic [1:0] c_op_or    = 2'b11;

    localparam logic [5:0] c_f_add   = 6'b100000;
    localparam logic [5:0] c_f_sub   = 6'b100010;
    localparam logic [5:0] c_f_and   = 6'b100100;
    localparam logic [5:0] c_f_or    = 6'b100101;
    localparam logic [5:0] c_f_slt   = 6'b101010;
    localparam logic [5:0] c_f_jr    = 6'b001000;
    localparam logic [5:0] c_f_mfhi  = 6'b010000;
    localparam logic [5:0] c_f_mflo  = 6'b010010;
    localparam logic [5:0] c_f_mult  = 6'b011000;
    localparam logic [5:0] c_f_multu = 6'b011001;
    localparam logic [5:0] c_f_div   = 6'b011010;
    localparam logic [5:0] c_f_divu  = 6'b011011;

    localparam logic [2:0] c_ula_add = 3'b010;
    localparam logic [2:0] c_ula_sub = 3'b110;
    localparam logic [2:0] c_ula_and = 3'b000;
    localparam logic [2:0] c_ula_or  = 3'b001;
    localparam logic [2:0] c_ula_slt = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        AJUSTE = 2'd3
    } estado_t;

    function automatic logic [2:0] decodifica_ula(input logic [1:0] op, input logic [5:0] f);
        logic [2:0] r;
        r = c_ula_add;
        case (op)
            c_op_add: r = c_ula_add;
            c_op_sub: r = c_ula_sub;
            c_op_or:  r = c_ula_or;
            default: begin
                case (f)
                    c_f_add: r = c_ula_add;
                    c_f_sub: r = c_ula_sub;
                    c_f_and: r = c_ula_and;
                    c_f_or:  r = c_ula_or;
                    c_f_slt: r = c_ula_slt;
                    default: r = c_ula_add;
                endcase
            end
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_mult_div.sv
`default_nettype none
// ============================================================================
// unidade_mult_div : iterative shift-add multiplier / restoring divider on
//                    unsigned magnitudes, with sign fix-up into HI/LO.
// Rev 1.0
// ============================================================================
module unidade_mult_div
    import ula_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  carregar_i,
    input  logic                  op_div_i,
    input  logic                  op_sinal_i,
    input  logic                  div0_i,
    input  logic                  iterar_i,
    input  logic                  ajustar_i,
    input  logic [DATA_WIDTH-1:0] operando_a_i,
    input  logic [DATA_WIDTH-1:0] operando_b_i,
    output logic                  cont_zero_o,
    output logic                  pronto_o,
    output logic                  erro_div0_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    // acc: partial product high half / remainder; mq: multiplier / quotient
    logic [DATA_WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opb_q, opb_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]         cont_q, cont_d;
    logic                  div_q, div_d, neg_q, neg_d, neg_r_q, neg_r_d;
    logic                  div0_q, div0_d, pronto_q, pronto_d, erro_q, erro_d;

    logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [DATA_WIDTH:0]     w_soma, w_resto_desl, w_dif;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_mag_a = (op_sinal_i && operando_a_i[DATA_WIDTH-1]) ? -operando_a_i : operando_a_i;
    assign w_mag_b = (op_sinal_i && operando_b_i[DATA_WIDTH-1]) ? -operando_b_i : operando_b_i;

    assign w_soma       = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    assign w_resto_desl = {acc_q, mq_q[DATA_WIDTH-1]};
    assign w_dif        = w_resto_desl - {1'b0, opb_q};
    assign w_prod       = {acc_q, mq_q};

    always_comb begin
        acc_d    = acc_q;
        mq_d     = mq_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cont_d   = cont_q;
        div_d    = div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        div0_d   = div0_q;
        pronto_d = 1'b0;
        erro_d   = 1'b0;

        if (carregar_i) begin
            div_d   = op_div_i;
            div0_d  = div0_i;
            neg_d   = op_sinal_i & (operando_a_i[DATA_WIDTH-1] ^ operando_b_i[DATA_WIDTH-1]);
            neg_r_d = op_sinal_i & operando_a_i[DATA_WIDTH-1];
            cont_d  = CW'(DATA_WIDTH - 1);
            opb_d   = w_mag_b;
            if (div0_i) begin
                // raw dividend goes straight to HI, LO reports all ones
                acc_d = operando_a_i;
                mq_d  = '1;
            end else begin
                acc_d = '0;
                mq_d  = w_mag_a;
            end
        end else if (iterar_i) begin
            if (cont_q != '0) begin
                cont_d = cont_q - 1'b1;
            end
            if (div_q) begin
                if (!w_dif[DATA_WIDTH]) begin
                    acc_d = w_dif[DATA_WIDTH-1:0];
                    mq_d  = {mq_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = w_resto_desl[DATA_WIDTH-1:0];
                    mq_d  = {mq_q[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = w_soma[DATA_WIDTH:1];
                mq_d  = {w_soma[0], mq_q[DATA_WIDTH-1:1]};
            end
        end else if (ajustar_i) begin
            pronto_d = 1'b1;
            if (div0_q) begin
                hi_d   = acc_q;
                lo_d   = mq_q;
                erro_d = 1'b1;
            end else if (div_q) begin
                lo_d = neg_q ? -mq_q : mq_q;
                hi_d = neg_r_q ? -acc_q : acc_q;
            end else begin
                {hi_d, lo_d} = neg_q ? -w_prod : w_prod;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q    <= '0;
            mq_q     <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cont_q   <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cont_q   <= cont_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
        end
    end

    assign cont_zero_o = (cont_q == '0);
    assign pronto_o    = pronto_q;
    assign erro_div0_o = erro_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule
`default_nettype wire

// File: rtl/controle_ula_seq.sv
`default_nettype none
// ============================================================================
// controle_ula_seq : ALU control decode plus a sequencer for iterative
//                    mult/multu/div/divu into HI/LO, stalling while busy.
// Rev 1.0
// ============================================================================
module controle_ula_seq
    import ula_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             ula_opcode,
    input  logic [FUNCT_WIDTH-1:0] funcao,
    input  logic                   valido,
    input  logic [DATA_WIDTH-1:0]  operando_a,
    input  logic [DATA_WIDTH-1:0]  operando_b,
    output logic [2:0]             ula_control,
    output logic                   controle_jr,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   erro_div0,
    output logic [DATA_WIDTH-1:0]  resultado_mf,
    output logic [DATA_WIDTH-1:0]  hi,
    output logic [DATA_WIDTH-1:0]  lo
);

    estado_t estado_q, estado_d;

    logic [5:0] w_funct;
    logic       w_eh_r, w_md, w_inicio, w_eh_div, w_sinal, w_div0, w_cont_zero;

    assign w_funct  = funcao[5:0];
    assign w_eh_r   = (ula_opcode == c_op_funct);
    assign w_md     = w_eh_r && ((w_funct == c_f_mult) || (w_funct == c_f_multu) ||
                                 (w_funct == c_f_div)  || (w_funct == c_f_divu));
    assign w_inicio = valido && w_md && (estado_q == OCIOSO);
    // funct bit 1 selects divide, bit 0 selects the unsigned variant
    assign w_eh_div = w_funct[1];
    assign w_sinal  = ~w_funct[0];
    assign w_div0   = w_eh_div && (operando_b == '0);

    assign ula_control = decodifica_ula(ula_opcode, w_funct);
    assign controle_jr = w_eh_r && (w_funct == c_f_jr);
    assign ocupado     = (estado_q != OCIOSO);

    always_comb begin
        resultado_mf = '0;
        if (w_eh_r && (w_funct == c_f_mfhi)) begin
            resultado_mf = hi;
        end else if (w_eh_r && (w_funct == c_f_mflo)) begin
            resultado_mf = lo;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (w_inicio) begin
                    if (!w_eh_div)   estado_d = MULT;
                    else if (w_div0) estado_d = AJUSTE;
                    else             estado_d = DIV;
                end
            end
            MULT, DIV: begin
                if (w_cont_zero) estado_d = AJUSTE;
            end
            AJUSTE:  estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    unidade_mult_div #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unidade_mult_div (
        .clk_i        (clock),
        .rst_n_i      (reset_n),
        .carregar_i   (w_inicio),
        .op_div_i     (w_eh_div),
        .op_sinal_i   (w_sinal),
        .div0_i       (w_div0),
        .iterar_i     ((estado_q == MULT) || (estado_q == DIV)),
        .ajustar_i    (estado_q == AJUSTE),
        .operando_a_i (operando_a),
        .operando_b_i (operando_b),
        .cont_zero_o  (w_cont_zero),
        .pronto_o     (pronto),
        .erro_div0_o  (erro_div0),
        .hi_o         (hi),
        .lo_o         (lo)
    );

endmodule
`default_nettype wire
